// File: rtl/l2_control.sv
// l2_control: L2 cache controller sequencer. Handles hits, dirty-victim
// writeback, line fill and the refetch lookup, and keeps hit/miss counters
// plus a sticky protocol error flag.
//
// Handshakes: mem_read/mem_write are level requests that are held until the
// one-cycle mem_resp. pmem_read/pmem_write are held until the one-cycle
// pmem_resp. A request that drops before completion is abandoned without a
// mem_resp. Any memory transaction already in flight still finishes first.
module l2_control (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  hit,
  input  logic [1:0]  lru_way,
  input  logic        victim_dirty,
  input  logic        pmem_resp,
  output logic        mem_resp,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic        arr_read,
  output logic        lru_load,
  output logic        lru_read,
  output logic [3:0]  lru_hit,
  output logic [3:0]  data_load,
  output logic        valid_set,
  output logic        dirty_set,
  output logic        dirty_clr,
  output logic        wb_sel,
  output logic        fill_sel,
  output logic [1:0]  way_sel,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    WRITEBACK = 3'd2,
    FILL      = 3'd3,
    REFETCH   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  victim_q, victim_d;
  logic        refill_q, refill_d;
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;
  logic        err_q, err_d;

  logic        req;
  logic        req_wr;
  logic        any_hit;
  logic        multi_hit;
  logic [3:0]  hit_oh;
  logic [1:0]  hit_way;
  logic [3:0]  victim_oh;

  // A simultaneous read and write is serviced as a read.
  assign req       = mem_read | mem_write;
  assign req_wr    = mem_write & ~mem_read;
  assign any_hit   = |hit;
  assign multi_hit = any_hit & ((hit & (hit - 4'd1)) != 4'd0);
  assign victim_oh = 4'b0001 << victim_q;

  // Priority-encode the hit vector so a multi-way hit resolves to the lowest way.
  always_comb begin
    hit_way = 2'd0;
    hit_oh  = 4'b0000;
    if (hit[0]) begin
      hit_way = 2'd0;
      hit_oh  = 4'b0001;
    end else if (hit[1]) begin
      hit_way = 2'd1;
      hit_oh  = 4'b0010;
    end else if (hit[2]) begin
      hit_way = 2'd2;
      hit_oh  = 4'b0100;
    end else if (hit[3]) begin
      hit_way = 2'd3;
      hit_oh  = 4'b1000;
    end
  end

  // State, victim, refill flag, counters and error flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      victim_q   <= 2'd0;
      refill_q   <= 1'b0;
      hit_cnt_q  <= 16'd0;
      miss_cnt_q <= 16'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      victim_q   <= victim_d;
      refill_q   <= refill_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      err_q      <= err_d;
    end
  end

  // Next-state, bookkeeping and combinational outputs. Holding rst_n low
  // forces every strobe to zero even though the state already reads IDLE.
  always_comb begin
    state_d    = state_q;
    victim_d   = victim_q;
    refill_d   = refill_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    err_d      = err_q | (mem_read & mem_write);

    mem_resp   = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    arr_read   = 1'b0;
    lru_load   = 1'b0;
    lru_read   = 1'b0;
    lru_hit    = 4'b0000;
    data_load  = 4'b0000;
    valid_set  = 1'b0;
    dirty_set  = 1'b0;
    dirty_clr  = 1'b0;
    wb_sel     = 1'b0;
    fill_sel   = 1'b0;
    way_sel    = 2'd0;

    if (rst_n) begin
      case (state_q)
        IDLE: begin
          if (req) begin
            arr_read = 1'b1;
            lru_read = 1'b1;
            state_d  = LOOKUP;
          end
        end

        LOOKUP: begin
          refill_d = 1'b0;
          if (!req) begin
            state_d = IDLE;
          end else if (any_hit) begin
            mem_resp = 1'b1;
            way_sel  = hit_way;
            lru_read = 1'b1;
            lru_load = 1'b1;
            lru_hit  = hit_oh;
            if (req_wr) begin
              data_load = hit_oh;
              dirty_set = 1'b1;
            end
            if (multi_hit) err_d = 1'b1;
            if (!refill_q && hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
            state_d = IDLE;
          end else begin
            victim_d = lru_way;
            if (refill_q) err_d = 1'b1;
            if (!refill_q && miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
            state_d = victim_dirty ? WRITEBACK : FILL;
          end
        end

        WRITEBACK: begin
          pmem_write = 1'b1;
          wb_sel     = 1'b1;
          way_sel    = victim_q;
          if (pmem_resp) state_d = req ? FILL : IDLE;
        end

        FILL: begin
          pmem_read = 1'b1;
          way_sel   = victim_q;
          if (pmem_resp) begin
            data_load = victim_oh;
            fill_sel  = 1'b1;
            valid_set = 1'b1;
            dirty_clr = 1'b1;
            state_d   = req ? REFETCH : IDLE;
          end
        end

        REFETCH: begin
          arr_read = 1'b1;
          lru_read = 1'b1;
          refill_d = 1'b1;
          state_d  = LOOKUP;
        end

        default: state_d = IDLE;
      endcase
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  assign err      = err_q;

endmodule

// File: tb/tb_l2_control.sv
// tb_l2_control: randomized and directed transactions against a
// transaction-level model of the controller (latency, selected way, counters,
// sticky error).
module tb_l2_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [3:0]  hit = 4'd0;
  logic [1:0]  lru_way = 2'd0;
  logic        victim_dirty = 1'b0;
  logic        pmem_resp = 1'b0;
  logic        mem_resp, pmem_read, pmem_write, arr_read, lru_load, lru_read;
  logic [3:0]  lru_hit, data_load;
  logic        valid_set, dirty_set, dirty_clr, wb_sel, fill_sel;
  logic [1:0]  way_sel;
  logic [15:0] hit_cnt, miss_cnt;
  logic        err;

  l2_control dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .hit(hit), .lru_way(lru_way), .victim_dirty(victim_dirty), .pmem_resp(pmem_resp),
    .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .arr_read(arr_read), .lru_load(lru_load), .lru_read(lru_read), .lru_hit(lru_hit),
    .data_load(data_load), .valid_set(valid_set), .dirty_set(dirty_set),
    .dirty_clr(dirty_clr), .wb_sel(wb_sel), .fill_sel(fill_sel), .way_sel(way_sel),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .err(err)
  );

  // Clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_hit  = 0;
  int          m_miss = 0;
  bit          m_err  = 1'b0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] low_way(input logic [3:0] h);
    logic [1:0] w;
    w = 2'd0;
    for (int i = 3; i >= 0; i--) if (h[i]) w = 2'(i);
    return w;
  endfunction

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic check_counters(input string tag);
    check({tag, "_hit_cnt"},  {16'd0, hit_cnt},  32'(m_hit));
    check({tag, "_miss_cnt"}, {16'd0, miss_cnt}, 32'(m_miss));
    check({tag, "_err"},      {31'd0, err},      {31'd0, m_err});
  endtask

  // Driver: one upstream request. h0 is presented to the first lookup, h1 to
  // the lookup after the first fill, a clean hit after any further fill.
  task automatic run_txn(input bit wr, input bit both, input logic [3:0] h0,
                         input logic [3:0] h1, input logic [1:0] lw, input bit vd,
                         input int wb_wait, input int fill_wait, input bit drop_fill);
    int          nmiss, lat, cyc, lookups, pm_cnt;
    logic [3:0]  hf, dl_exp;
    logic [1:0]  w;
    bit          done, dropped, exp_wr;
    logic [31:0] got, e;

    // Model: how many misses precede the final hit and what that hit selects.
    nmiss  = (h0 != 4'd0) ? 0 : ((h1 != 4'd0) ? 1 : 2);
    hf     = (nmiss == 0) ? h0 : ((nmiss == 1) ? h1 : 4'b0001);
    w      = low_way(hf);
    lat    = 2 + nmiss * ((vd ? wb_wait + 1 : 0) + fill_wait + 3);
    exp_wr = wr && !both;
    dl_exp = exp_wr ? (4'b0001 << w) : 4'b0000;
    if (nmiss == 0) m_hit = sat16(m_hit + 1);
    else            m_miss = sat16(m_miss + 1);
    if (both || nmiss == 2 || (!drop_fill && $countones(hf) > 1)) m_err = 1'b1;
    if (!drop_fill)
      exp_q.push_back({12'd0, 8'(lat), w, 4'b0001 << w, dl_exp, exp_wr, 1'b1});

    cyc = 0; lookups = 0; pm_cnt = 0; done = 1'b0; dropped = 1'b0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        mem_read     = !wr || both;
        mem_write    = wr || both;
        lru_way      = lw;
        victim_dirty = vd;
      end
      hit       = (lookups == 0) ? h0 : ((lookups == 1) ? h1 : 4'b0001);
      pmem_resp = 1'b0;
      #1;
      if (cyc == 1) check("accept_strobes", {30'd0, arr_read, lru_read}, 32'd3);
      if (pmem_write) begin
        if (pm_cnt == 0) begin
          check("wb_sel", {31'd0, wb_sel}, 32'd1);
          check("wb_way", {30'd0, way_sel}, {30'd0, lw});
        end
        if (pm_cnt == wb_wait) begin pmem_resp = 1'b1; pm_cnt = 0; end
        else pm_cnt++;
      end else if (pmem_read) begin
        if (pm_cnt == 0) check("fill_way", {30'd0, way_sel}, {30'd0, lw});
        if (drop_fill && !dropped) begin
          mem_read = 1'b0; mem_write = 1'b0; dropped = 1'b1;
        end
        if (pm_cnt == fill_wait) begin
          pmem_resp = 1'b1;
          #1;
          check("fill_data_load", {28'd0, data_load}, {28'd0, 4'b0001 << lw});
          check("fill_ctl", {29'd0, fill_sel, valid_set, dirty_clr}, 32'd7);
          lookups++; pm_cnt = 0;
          if (dropped) done = 1'b1;
        end else pm_cnt++;
      end
      if (mem_resp) begin
        if (dropped) check("drop_no_resp", 32'd1, 32'd0);
        else if (exp_q.size() == 0) check("resp_unexpected", 32'd1, 32'd0);
        else begin
          e   = exp_q.pop_front();
          got = {12'd0, 8'(cyc), way_sel, lru_hit, data_load, dirty_set, lru_load};
          check("resp", got, e);
        end
        done = 1'b1;
      end
    end
    if (!done) check("timeout", 32'd0, 32'd1);
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
    #1;
    check("back_to_idle", {29'd0, mem_resp, pmem_read, arr_read}, 32'd0);
  endtask

  task automatic reset_mid_wb();
    int n;
    n = 0;
    @(negedge clk);
    mem_read = 1'b1; hit = 4'd0; lru_way = 2'd3; victim_dirty = 1'b1;
    do begin
      @(negedge clk); #1; n++;
    end while (!pmem_write && n < 20);
    check("wb_reached", {31'd0, pmem_write}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_pmem_write", {31'd0, pmem_write}, 32'd0);
    check("rst_strobes", {26'd0, arr_read, lru_read, wb_sel, mem_resp, way_sel}, 32'd0);
    m_hit = 0; m_miss = 0; m_err = 1'b0;
    check_counters("rst_mid_wb");
    @(negedge clk);
    mem_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Stimulus
  initial begin
    logic [3:0] h0;
    bit         wr;
    // Reset block: outputs stay low while reset holds, even with a request.
    mem_read = 1'b1;
    #3;
    check("reset_strobes", {30'd0, arr_read, lru_read}, 32'd0);
    mem_read = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_counters("reset");

    // Read hit on way 2; write hit on way 0.
    run_txn(1'b0, 1'b0, 4'b0100, 4'b0001, 2'd0, 1'b0, 0, 0, 1'b0);
    check_counters("read_hit");
    run_txn(1'b1, 1'b0, 4'b0001, 4'b0001, 2'd0, 1'b0, 0, 0, 1'b0);
    check_counters("write_hit");
    // Dirty miss on way 3 with 5-cycle memory waits.
    run_txn(1'b0, 1'b0, 4'b0000, 4'b1000, 2'd3, 1'b1, 5, 5, 1'b0);
    check_counters("dirty_miss");

    // Randomized one-hot traffic.
    for (int i = 0; i < 24; i++) begin
      wr = 1'($urandom_range(0, 1));
      h0 = ($urandom_range(0, 1) == 0) ? 4'd0 : (4'b0001 << $urandom_range(0, 3));
      run_txn(wr, 1'b0, h0, 4'b0001 << $urandom_range(0, 3), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 4), 1'b0);
    end
    check_counters("random");

    // Request dropped during fill.
    run_txn(1'b0, 1'b0, 4'b0000, 4'b0010, 2'd1, 1'b1, 2, 3, 1'b1);
    check_counters("drop_fill");

    // Error cases: multi-hit, read+write together, refill lookup miss.
    run_txn(1'b0, 1'b0, 4'b0110, 4'b0001, 2'd0, 1'b0, 0, 0, 1'b0);
    check_counters("multi_hit");
    run_txn(1'b1, 1'b1, 4'b0001, 4'b0001, 2'd0, 1'b0, 0, 0, 1'b0);
    check_counters("rd_wr_both");
    run_txn(1'b0, 1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, 0, 1, 1'b0);
    check_counters("refill_miss");

    // Reset in the middle of a writeback clears everything.
    reset_mid_wb();
    run_txn(1'b0, 1'b0, 4'b1000, 4'b0001, 2'd0, 1'b0, 0, 0, 1'b0);
    check_counters("after_reset");

    // Counter saturation.
    @(negedge clk);
    force dut.hit_cnt_q = 16'hFFFE;
    force dut.miss_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.hit_cnt_q;
    release dut.miss_cnt_q;
    m_hit = 65534; m_miss = 65535;
    run_txn(1'b0, 1'b0, 4'b0010, 4'b0001, 2'd0, 1'b0, 0, 0, 1'b0);
    check_counters("sat_reach");
    run_txn(1'b1, 1'b0, 4'b0001, 4'b0001, 2'd0, 1'b0, 0, 0, 1'b0);
    run_txn(1'b0, 1'b0, 4'b0000, 4'b0100, 2'd1, 1'b0, 0, 1, 1'b0);
    check_counters("sat_hold");

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/l2_control.md
L2_CONTROL -- requirements
Module: l2_control

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: mem_read, mem_write  in  1 each  upstream request, held until mem_resp.
REQ-004 SHALL have ports: hit  in  4  per-way tag match from datapath, valid in LOOKUP.
REQ-005 SHALL have ports: lru_way  in  2  way chosen by pseudo-LRU, valid in LOOKUP.
REQ-006 SHALL have ports: victim_dirty  in  1  dirty bit of way lru_way, valid in LOOKUP.
REQ-007 SHALL have ports: pmem_resp  in  1  physical-memory completion pulse.
REQ-008 SHALL have ports: mem_resp  out  1  upstream completion, one cycle.
REQ-009 SHALL have ports: pmem_read, pmem_write  out  1 each  physical-memory request, held until pmem_resp.
REQ-010 SHALL have ports: arr_read  out  1  tag/data/valid/dirty/LRU array read strobe.
REQ-011 SHALL have ports: lru_load, lru_read  out  1 each  LRU array control.
REQ-012 SHALL have ports: lru_hit  out  4  one-hot way passed to LRU update.
REQ-013 SHALL have ports: data_load  out  4  per-way data/tag write enable.
REQ-014 SHALL have ports: valid_set, dirty_set, dirty_clr, wb_sel, fill_sel  out  1 each  datapath controls.
REQ-015 SHALL have ports: way_sel  out  2  data/tag output mux select.
REQ-016 SHALL have ports: hit_cnt, miss_cnt  out  16 each  performance counters.
REQ-017 SHALL have ports: err  out  1  sticky protocol error.

Function
REQ-018 States SHALL be IDLE, LOOKUP, WRITEBACK, FILL, REFETCH.
REQ-019 IDLE, (mem_read|mem_write)=1: assert arr_read, lru_read; next LOOKUP. Otherwise stay IDLE, all strobes 0.
REQ-020 LOOKUP, |hit=1, read: mem_resp=1, way_sel=encode(hit), lru_read=1, lru_load=1, lru_hit=hit; next IDLE.
REQ-021 LOOKUP, |hit=1, write: additionally data_load=hit, dirty_set=1; same other outputs as REQ-020.
REQ-022 LOOKUP, hit=0: register victim=lru_way; next WRITEBACK if victim_dirty, else FILL; no mem_resp.
REQ-023 WRITEBACK: pmem_write=1, wb_sel=1, way_sel=victim; on pmem_resp next FILL.
REQ-024 FILL: pmem_read=1, way_sel=victim; on pmem_resp, same cycle: data_load[victim]=1, fill_sel=1, valid_set=1, dirty_clr=1; next REFETCH.
REQ-025 REFETCH: arr_read=1, lru_read=1; next LOOKUP; a refill flag SHALL mark that lookup.
REQ-026 The refill LOOKUP SHALL hit; if it misses, err SHALL set and the miss path of REQ-022 SHALL repeat.
REQ-027 Latency: hit = 2 cycles request-to-mem_resp; clean miss = 4 cycles plus fill wait; dirty miss adds the writeback wait.
REQ-028 hit_cnt SHALL +1 per hitting LOOKUP whose refill flag is clear; miss_cnt SHALL +1 per missing LOOKUP whose refill flag is clear.
REQ-029 Both counters SHALL saturate at 0xFFFF.
REQ-030 hit not one-hot and nonzero: err SHALL set; the lowest set way SHALL be used for way_sel, lru_hit and data_load.
REQ-031 mem_read and mem_write both 1: err SHALL set; the request SHALL be serviced as a read.
REQ-032 Request dropped in WRITEBACK/FILL: the memory transaction SHALL complete; on pmem_resp the next state SHALL be IDLE with no mem_resp; FILL writes SHALL still occur.
REQ-033 pmem_resp outside WRITEBACK/FILL SHALL be ignored.
REQ-034 Request dropped in LOOKUP: next state SHALL be IDLE with no outputs asserted.
REQ-035 Outputs SHALL be combinational from state and inputs; victim, refill flag, counters and err SHALL be registered.

Reset
REQ-036 rst_n=0 SHALL immediately force IDLE; victim=0; refill=0; hit_cnt=miss_cnt=0; err=0.
REQ-037 While rst_n=0, all outputs SHALL be 0, including any in-flight pmem_read/pmem_write.
REQ-038 After rst_n rises, the first request SHALL be accepted on the next clock edge.

Verification
REQ-039 Read hit: mem_read=1, hit=4'b0100 in LOOKUP -> mem_resp at cycle 2, way_sel=2, lru_hit=4'b0100, lru_load=1, hit_cnt=1.
REQ-040 Write hit: mem_write=1, hit=4'b0001 -> data_load=4'b0001, dirty_set=1, mem_resp at cycle 2.
REQ-041 Dirty miss: mem_read=1, hit=0, lru_way=3, victim_dirty=1, pmem_resp after 5 cycles each.
REQ-041 (cont.) Expected: WRITEBACK (wb_sel=1, way_sel=3), then FILL (data_load=4'b1000 on pmem_resp), then REFETCH, then LOOKUP hit, then mem_resp; miss_cnt=1, hit_cnt=0.
REQ-042 Drop and reset: mem_read drops during FILL -> pmem_resp returns to IDLE, no mem_resp.
REQ-042 (cont.) rst_n low mid-WRITEBACK -> pmem_write=0 the same cycle, counters 0.
REQ-043 Errors: hit=4'b0110 -> err=1, way_sel=1; mem_read=mem_write=1 -> err=1, no data_load.
REQ-044 Saturation: preload 0xFFFF hits, one more hit -> hit_cnt stays 0xFFFF.
